// File: rtl/mem_port_arbiter_rr.sv
// Round-robin arbiter sharing one cacheline memory port among N_CH requesters, with per-channel grant/wait counters.
// Latency: strobe one cycle after a request is seen in IDLE; req_resp is combinational with mem_resp; one IDLE cycle between transactions.
// Backpressure: requests are held until req_resp; a grant is locked until mem_resp and losers simply keep waiting.
module mem_port_arbiter_rr #(
  parameter int N_CH   = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_read,
  input  logic [N_CH-1:0]          req_write,
  input  logic [N_CH*ADDR_W-1:0]   req_address,
  input  logic [N_CH*LINE_W-1:0]   req_wdata,
  output logic [LINE_W-1:0]        req_rdata,
  output logic [N_CH-1:0]          req_resp,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [LINE_W-1:0]        mem_wdata,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_resp,
  input  logic [N_CH-1:0]          count_clear,
  output logic [N_CH*CNT_W-1:0]    grant_count,
  output logic [N_CH*CNT_W-1:0]    wait_count
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    grant_cnt_q [N_CH];
  logic [CNT_W-1:0]    grant_cnt_d [N_CH];
  logic [CNT_W-1:0]    wait_cnt_q  [N_CH];
  logic [CNT_W-1:0]    wait_cnt_d  [N_CH];

  logic [N_CH-1:0]     req;
  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      cand;
  logic                win_wr;
  logic [ADDR_W-1:0]   win_addr;
  logic [LINE_W-1:0]   win_wdata;
  logic                done;
  logic [N_CH-1:0]     grant_inc;
  logic [N_CH-1:0]     wait_inc;

  // A write wins over a read when a channel raises both.
  assign req  = req_read | req_write;
  assign done = (state_q == BUSY) && mem_resp;

  // Pick the first requester at or above the pointer (wrapping) and mux out its operands.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    cand      = '0;
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_CH)) cand = cand - (IDX_W+1)'(N_CH);
      if (!win_vld && req[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_wr    = req_write[i];
        win_addr  = req_address[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  // Next-state logic: grant and latch operands in IDLE, release and rotate the pointer on mem_resp.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          gnt_d   = win_idx;
          op_wr_d = win_wr;
          addr_d  = win_addr;
          wdata_d = win_wdata;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == IDX_W'(N_CH-1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter next-state: saturating increments, clear beats increment.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      grant_inc[i] = (state_q == IDLE) && win_vld && (win_idx == IDX_W'(i));
      wait_inc[i]  = req[i] &&
                     (((state_q == BUSY) && (gnt_q != IDX_W'(i))) ||
                      ((state_q == IDLE) && win_vld && (win_idx != IDX_W'(i))));
      grant_cnt_d[i] = grant_cnt_q[i];
      wait_cnt_d[i]  = wait_cnt_q[i];
      if (grant_inc[i] && (grant_cnt_q[i] != '1)) grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
      if (wait_inc[i]  && (wait_cnt_q[i]  != '1)) wait_cnt_d[i]  = wait_cnt_q[i] + 1'b1;
      if (count_clear[i]) begin
        grant_cnt_d[i] = '0;
        wait_cnt_d[i]  = '0;
      end
    end
  end

  // State, latched transaction and counters; reset abandons any downstream transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        grant_cnt_q[i] <= '0;
        wait_cnt_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      for (int i = 0; i < N_CH; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        wait_cnt_q[i]  <= wait_cnt_d[i];
      end
    end
  end

  // Completion pulse goes only to the locked channel, in the same cycle as mem_resp.
  always_comb begin
    req_resp = '0;
    if (done) req_resp[gnt_q] = 1'b1;
  end

  assign req_rdata   = mem_rdata;
  assign mem_read    = (state_q == BUSY) && !op_wr_q;
  assign mem_write   = (state_q == BUSY) &&  op_wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_cnt_out
    assign grant_count[i*CNT_W +: CNT_W] = grant_cnt_q[i];
    assign wait_count[i*CNT_W +: CNT_W]  = wait_cnt_q[i];
  end

endmodule

// File: tb/tb_mem_port_arbiter_rr.sv
// Bench for mem_port_arbiter_rr: 3 channels, 64-bit lines, 4-bit counters.
// Expected grants are queued when requests are driven and popped when the strobe appears.
// A responder inside the stimulus drives mem_resp after a chosen latency.
module tb_mem_port_arbiter_rr;
  localparam int N  = 3;
  localparam int LW = 64;
  localparam int AW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_read = '0, req_write = '0, req_resp, count_clear = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N*LW-1:0] req_wdata = '0;
  logic [LW-1:0]   req_rdata, mem_wdata, mem_rdata = '0;
  logic [AW-1:0]   mem_address;
  logic            mem_read, mem_write, mem_resp = 1'b0;
  logic [N*CW-1:0] grant_count, wait_count;

  typedef struct {int ch; bit wr; logic [AW-1:0] addr; logic [LW-1:0] wd;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  mem_port_arbiter_rr #(.N_CH(N), .LINE_W(LW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .req_resp(req_resp), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .count_clear(count_clear),
    .grant_count(grant_count), .wait_count(wait_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int ch);
    return 32'h0000_0100 * (ch + 1);
  endfunction

  function automatic logic [LW-1:0] data_of(input int ch);
    return {32'hDA7A_0000 + ch, 32'h1234_5670 + ch};
  endfunction

  function automatic logic [CW-1:0] gcnt(input int ch);
    return grant_count[ch*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] wcnt(input int ch);
    return wait_count[ch*CW +: CW];
  endfunction

  task automatic set_req(input int ch, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] d, input bit push);
    exp_t e;
    req_read[ch]  = rd;
    req_write[ch] = wr;
    req_address[ch*AW +: AW] = a;
    req_wdata[ch*LW +: LW]   = d;
    e = '{ch, wr, a, d};
    if (push) sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_resp = 1'b0;
    req_read = '0;
    req_write = '0;
    count_clear = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a downstream strobe, then compare it with the oldest expectation.
  task automatic wait_grant(output exp_t e, output int cyc);
    cyc = 0;
    e = '{0, 1'b0, '0, '0};
    @(negedge clk);
    while (!(mem_read || mem_write) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("strobe_seen", 64'(cyc < 100), 64'd1);
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) e = sb.pop_front();
    check("mem_address", 64'(mem_address), 64'(e.addr));
    check("mem_op", {62'd0, mem_write, mem_read}, e.wr ? 64'd2 : 64'd1);
    check("mem_wdata", mem_wdata, e.wd);
  endtask

  // Called at a negedge while BUSY: respond, check the completion, release the requester.
  task automatic respond(input exp_t e, input bit keep);
    logic [LW-1:0] rd;
    rd = {$urandom, $urandom};
    mem_rdata = rd;
    mem_resp = 1'b1;
    #1;
    check("req_resp", 64'(req_resp), 64'd1 << e.ch);
    check("req_rdata", req_rdata, rd);
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    if (!keep) begin
      req_read[e.ch]  = 1'b0;
      req_write[e.ch] = 1'b0;
    end
    @(negedge clk);
    check("idle_gap", {62'd0, mem_write, mem_read}, 64'd0);
  endtask

  task automatic serve(input int lat, input bit keep, output exp_t e, output int cyc);
    logic [1:0] op;
    wait_grant(e, cyc);
    op = {mem_write, mem_read};
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("strobe_held", {62'd0, mem_write, mem_read}, 64'(op));
    end
    respond(e, keep);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cyc;

    // Reset state
    @(negedge clk);
    check("rst_strobes", {62'd0, mem_write, mem_read}, 64'd0);
    check("rst_resp", 64'(req_resp), 64'd0);
    check("rst_gcnt", 64'(grant_count), 64'd0);
    check("rst_wcnt", 64'(wait_count), 64'd0);
    do_reset();

    // Single read on ch0, responder 3 cycles after the strobe
    set_req(0, 1'b1, 1'b0, addr_of(0), data_of(0), 1'b1);
    serve(3, 1'b0, e, cyc);
    check("first_strobe_latency", 64'(cyc), 64'd0);
    check("t1_gcnt0", 64'(gcnt(0)), 64'd1);
    check("t1_wcnt0", 64'(wcnt(0)), 64'd0);

    // ch0 and ch1 together from reset; ch0 re-requests at once
    do_reset();
    set_req(0, 1'b1, 1'b0, addr_of(0), data_of(0), 1'b1);
    set_req(1, 1'b1, 1'b0, addr_of(1), data_of(1), 1'b1);
    e = '{0, 1'b0, addr_of(0), data_of(0)};
    sb.push_back(e);
    serve(2, 1'b1, e, cyc);
    check("t2_wcnt1", 64'(wcnt(1)), 64'd4);
    serve(1, 1'b0, e, cyc);
    serve(0, 1'b0, e, cyc);
    check("t2_gcnt0", 64'(gcnt(0)), 64'd2);
    check("t2_gcnt1", 64'(gcnt(1)), 64'd1);

    // All three channels requesting continuously for 9 transactions
    do_reset();
    for (int c = 0; c < N; c++) set_req(c, 1'b1, 1'b0, addr_of(c), data_of(c), 1'b0);
    for (int k = 0; k < 9; k++) begin
      e = '{k % N, 1'b0, addr_of(k % N), data_of(k % N)};
      sb.push_back(e);
    end
    for (int k = 0; k < 9; k++) serve(int'($urandom_range(0, 2)), 1'b1, e, cyc);
    req_read = '0;
    for (int c = 0; c < N; c++) check("t3_gcnt", 64'(gcnt(c)), 64'd3);
    check("t3_sb_drained", 64'(sb.size()), 64'd0);

    // Read and write together on ch2 become a write
    do_reset();
    set_req(2, 1'b1, 1'b1, 32'h0000_1000, 64'hFEED_FACE_0BAD_F00D, 1'b1);
    serve(1, 1'b0, e, cyc);
    check("t4_gcnt2", 64'(gcnt(2)), 64'd1);

    // Reset in the middle of a transaction, then a late mem_resp
    do_reset();
    set_req(0, 1'b1, 1'b0, addr_of(0), data_of(0), 1'b1);
    serve(1, 1'b0, e, cyc);
    set_req(1, 1'b1, 1'b0, addr_of(1), data_of(1), 1'b1);
    wait_grant(e, cyc);
    rst = 1'b1;
    #1;
    check("t5_async_drop", {62'd0, mem_write, mem_read}, 64'd0);
    req_read = '0;
    mem_resp = 1'b1;
    #1;
    check("t5_resp_in_rst", 64'(req_resp), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_late_resp", 64'(req_resp), 64'd0);
    check("t5_strobes", {62'd0, mem_write, mem_read}, 64'd0);
    check("t5_gcnt", 64'(grant_count), 64'd0);
    check("t5_wcnt", 64'(wait_count), 64'd0);
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, addr_of(0), data_of(0), 1'b1);
    set_req(1, 1'b1, 1'b0, addr_of(1), data_of(1), 1'b1);
    serve(0, 1'b0, e, cyc);
    serve(0, 1'b0, e, cyc);

    // ch1 starved by a long ch0 transaction; saturation and clear priority
    do_reset();
    set_req(0, 1'b1, 1'b0, addr_of(0), data_of(0), 1'b1);
    set_req(1, 1'b1, 1'b0, addr_of(1), data_of(1), 1'b1);
    wait_grant(e, cyc);
    repeat (20) @(negedge clk);
    check("t6_wcnt1_sat", 64'(wcnt(1)), 64'd15);
    count_clear = 3'b010;
    @(negedge clk);
    check("t6_clear", 64'(wcnt(1)), 64'd0);
    count_clear = '0;
    @(negedge clk);
    check("t6_recount", 64'(wcnt(1)), 64'd1);
    count_clear = 3'b010;
    @(negedge clk);
    check("t6_clear_vs_inc", 64'(wcnt(1)), 64'd0);
    count_clear = '0;
    respond(e, 1'b0);
    serve(0, 1'b0, e, cyc);
    check("t6_gcnt0", 64'(gcnt(0)), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter_rr.md
Name: mem_port_arbiter_rr

Overview:
- Parametrised N-channel round-robin arbiter for a shared cacheline memory port, with per-channel performance counters.
- It generalises the fixed two-client (instruction/data) memory path into N requesters, for example L1I, L1D and a prefetcher, that share one downstream port to L2 or pmem.
- Each grant is locked until the downstream response arrives.
- Per-channel grant and wait counters support the team's hit/miss performance instrumentation.

Parameters:
- N_CH, 2, number of requesting channels (2..8).
- LINE_W, 256, cacheline data width in bits.
- ADDR_W, 32, address width in bits.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_read  in  N_CH  per-channel read request; held until the matching req_resp.
- req_write  in  N_CH  per-channel write request; held until the matching req_resp.
- req_address  in  N_CH*ADDR_W  flattened addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_CH*LINE_W  flattened write lines.
- req_rdata  out  LINE_W  read line, broadcast to all channels.
- req_resp  out  N_CH  one-hot completion pulse.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  LINE_W  downstream write line.
- mem_read  out  1  downstream read strobe.
- mem_write  out  1  downstream write strobe.
- mem_rdata  in  LINE_W  downstream read line.
- mem_resp  in  1  downstream completion.
- count_clear  in  N_CH  synchronous per-channel counter clear.
- grant_count  out  N_CH*CNT_W  transactions granted per channel.
- wait_count  out  N_CH*CNT_W  cycles each channel spent requesting without being served.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE; priority pointer=0; latched grant/address/wdata/op cleared.
  - mem_read=mem_write=0; req_resp=0; all counters=0.
  - An outstanding downstream transaction is abandoned, and a late mem_resp after reset is ignored.
- Request definition: req_i = req_read[i] | req_write[i]. If both are high, the transaction is a write.
- IDLE:
  - If any req_i is set, select the first requesting channel scanning upward from the priority pointer, modulo N_CH.
  - Register the grant index g, the op, req_address[g] and req_wdata[g]; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_read/mem_write driven from the registered op; mem_address/mem_wdata driven from registered values, stable for the whole transaction.
  - On mem_resp=1, combinationally in the same cycle:
    - req_resp[g]=1, all other bits 0; req_rdata=mem_rdata.
    - Next state IDLE; pointer <= (g+1) mod N_CH.
  - mem_read/mem_write drop in the following cycle.
- Latency:
  - Request first seen in IDLE at cycle t → strobe asserted at cycle t+1.
  - Total latency = 1 + downstream latency.
  - Minimum gap of one IDLE cycle between back-to-back transactions.
- Requester rules:
  - Channel g deasserts its request the cycle after req_resp.
  - Other channels' request, address and data may change freely until they are granted; they are sampled only at grant.
- mem_resp while in IDLE: ignored.
- req_rdata when no response is pending: drives mem_rdata (don't-care to clients).
- Fairness: with all N_CH channels requesting continuously, each channel is served exactly once every N_CH transactions.
- grant_count[i]:
  - +1 on the IDLE→BUSY cycle with g=i.
  - Saturates at 2^CNT_W−1; no wrap.
- wait_count[i]:
  - +1 each cycle req_i=1 and channel i is not the granted channel, either in BUSY or on an IDLE cycle where another channel wins.
  - Saturates at 2^CNT_W−1.
- count_clear[i]: zeroes both counters of channel i at the next edge; takes priority over a simultaneous increment.

Test Plan:
- Single read on ch0, downstream responds 3 cycles after strobe → mem_read high cycles t+1..t+4, req_resp=2'b01 coincident with mem_resp, req_rdata=mem_rdata, grant_count0=1, wait_count0=0.
- ch0 and ch1 requesting simultaneously from reset → ch0 served first, then ch1; wait_count1 = ch0 transaction cycles + 1; ch0 re-requests immediately and ch1 is still served before ch0's second transaction.
- N_CH=3, all channels requesting continuously for 9 transactions → grant order 0,1,2,0,1,2,0,1,2; grant_count = 3 each.
- Channel asserts req_read and req_write together with address 0x0000_1000 → mem_write=1, mem_read=0, mem_address=0x0000_1000, mem_wdata = that channel's line.
- rst pulsed mid-BUSY, then mem_resp arrives → mem_read drops without waiting for a clock edge; no req_resp is generated; counters are 0; pointer is 0.
- CNT_W=4, ch1 starved for 20 cycles → wait_count1 saturates at 15; count_clear[1] asserted in the same cycle as an increment → counter reads 0.
